// File: rtl/obstacle_pkg.sv
// Shared obstacle table types and widths used by the slot manager and by
// its consumers (track_draw, death).
package obstacle_pkg;

  localparam int OBST_POS_W    = 11;
  localparam int OBST_TYPE_W   = 2;
  localparam int LANE_W        = 2;
  localparam int NUM_OBSTACLES = 10;

  typedef struct packed {
    logic [OBST_TYPE_W-1:0] obst_type;
    logic [OBST_POS_W-1:0]  pos;
    logic [LANE_W-1:0]      lane;
    logic                   active;
  } obstacle_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_ADVANCE = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/slot_priority_enc.sv
// Lowest-index inactive slot finder; purely combinational, no backpressure.
module slot_priority_enc #(
  parameter int N     = 10,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     active_vec,
  output logic [IDX_W-1:0] free_idx,
  output logic             free_found
);

  // Scan from the top down so the last hit is the lowest free index.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!active_vec[i]) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/obstacle_slot_manager.sv
// Obstacle table owner: spawn accept lands next cycle, a frame sweep takes NUM_SLOTS cycles.
// Spawns stall (spawn_ready=0) while sweeping, pending, resetting or full.
module obstacle_slot_manager
  import obstacle_pkg::*;
#(
  parameter int                    NUM_SLOTS = NUM_OBSTACLES,
  parameter logic [OBST_POS_W-1:0] SPAWN_POS = 11'd1023,
  parameter int                    SPEED_W   = 4
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               game_reset,
  input  logic                               frame_trigger,
  input  logic [SPEED_W-1:0]                 speed,
  input  logic                               spawn_valid,
  output logic                               spawn_ready,
  input  logic [OBST_TYPE_W-1:0]             spawn_type,
  input  logic [LANE_W-1:0]                  spawn_lane,
  output obstacle_t [NUM_SLOTS-1:0]          obstacles_out,
  output logic [$clog2(NUM_SLOTS+1)-1:0]     occupancy,
  output logic                               passed_pulse,
  output logic                               frame_overrun,
  output logic                               busy
);

  localparam int OCC_W = $clog2(NUM_SLOTS + 1);
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(NUM_SLOTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  sweep_state_t              state_q, state_d;
  obstacle_t [NUM_SLOTS-1:0] table_q, table_d;
  logic [OCC_W-1:0]          occ_q, occ_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [SPEED_W-1:0]        spd_q, spd_d;
  logic                      pending_q, pending_d;
  logic                      passed_q, passed_d;
  logic                      overrun_q, overrun_d;
  logic                      ready_en_q, ready_en_d;

  logic [NUM_SLOTS-1:0]      active_vec;
  logic [IDX_W-1:0]          free_idx;
  logic                      free_found;
  logic                      spawn_accept;
  logic [OBST_POS_W-1:0]     spd_ext;
  obstacle_t                 cur;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      active_vec[i] = table_q[i].active;
    end
  end

  slot_priority_enc #(
    .N     (NUM_SLOTS),
    .IDX_W (IDX_W)
  ) u_prio (
    .active_vec (active_vec),
    .free_idx   (free_idx),
    .free_found (free_found)
  );

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      table_q    <= '0;
      occ_q      <= '0;
      idx_q      <= '0;
      spd_q      <= '0;
      pending_q  <= 1'b0;
      passed_q   <= 1'b0;
      overrun_q  <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      table_q    <= table_d;
      occ_q      <= occ_d;
      idx_q      <= idx_d;
      spd_q      <= spd_d;
      pending_q  <= pending_d;
      passed_q   <= passed_d;
      overrun_q  <= overrun_d;
      ready_en_q <= ready_en_d;
    end
  end

  // Next-state: sweep sequencing and frame trigger bookkeeping
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    spd_d      = spd_q;
    pending_d  = pending_q;
    overrun_d  = 1'b0;
    ready_en_d = 1'b1;
    if (game_reset) begin
      state_d   = ST_IDLE;
      pending_d = 1'b0;
      idx_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_trigger || pending_q) begin
            state_d   = ST_ADVANCE;
            pending_d = 1'b0;
            idx_d     = '0;
            spd_d     = speed;
          end
        end
        ST_ADVANCE: begin
          // Only one trigger can be queued behind the running sweep.
          if (frame_trigger) begin
            if (!pending_q) pending_d = 1'b1;
            else            overrun_d = 1'b1;
          end
          if (idx_q == LAST_IDX) state_d = ST_IDLE;
          else                   idx_d   = idx_q + 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Table write port: exactly one of clear / advance / spawn per cycle
  always_comb begin
    table_d  = table_q;
    occ_d    = occ_q;
    passed_d = 1'b0;
    spd_ext  = {{(OBST_POS_W - SPEED_W){1'b0}}, spd_q};
    cur      = table_q[idx_q];
    if (game_reset) begin
      table_d = '0;
      occ_d   = '0;
    end else if (state_q == ST_ADVANCE) begin
      if (cur.active) begin
        if (cur.pos <= spd_ext) begin
          table_d[idx_q].active = 1'b0;
          occ_d                 = occ_q - 1'b1;
          passed_d              = 1'b1;
        end else begin
          table_d[idx_q].pos = cur.pos - spd_ext;
        end
      end
    end else if (spawn_accept && free_found) begin
      table_d[free_idx] = '{obst_type: spawn_type, pos: SPAWN_POS,
                            lane: spawn_lane, active: 1'b1};
      occ_d             = occ_q + 1'b1;
    end
  end

  // Outputs
  always_comb begin
    spawn_ready   = ready_en_q && (state_q == ST_IDLE) && !pending_q &&
                    !frame_trigger && !game_reset && (occ_q < FULL_CNT);
    spawn_accept  = spawn_valid && spawn_ready;
    busy          = (state_q == ST_ADVANCE);
    obstacles_out = table_q;
    occupancy     = occ_q;
    passed_pulse  = passed_q;
    frame_overrun = overrun_q;
  end

endmodule

// File: tb/tb_obstacle_slot_manager.sv
// Directed bench for obstacle_slot_manager: spawn, sweep/retire, full table,
// queued/overrun triggers, game_reset and rst_in mid-sweep.
module tb_obstacle_slot_manager;
  import obstacle_pkg::*;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b1;
  logic            game_reset = 1'b0;
  logic            frame_trigger = 1'b0;
  logic [3:0]      speed = '0;
  logic            spawn_valid = 1'b0;
  logic            spawn_ready;
  logic [1:0]      spawn_type = '0;
  logic [1:0]      spawn_lane = '0;
  obstacle_t [9:0] obs;
  logic [3:0]      occupancy;
  logic            passed_pulse;
  logic            frame_overrun;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  obstacle_slot_manager dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .game_reset    (game_reset),
    .frame_trigger (frame_trigger),
    .speed         (speed),
    .spawn_valid   (spawn_valid),
    .spawn_ready   (spawn_ready),
    .spawn_type    (spawn_type),
    .spawn_lane    (spawn_lane),
    .obstacles_out (obs),
    .occupancy     (occupancy),
    .passed_pulse  (passed_pulse),
    .frame_overrun (frame_overrun),
    .busy          (busy)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not reach its end, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_table();
    game_reset = 1'b1;
    tick();
    game_reset = 1'b0;
  endtask

  task automatic spawn_one(input logic [1:0] t, input logic [1:0] l);
    spawn_type  = t;
    spawn_lane  = l;
    spawn_valid = 1'b1;
    tick();
    spawn_valid = 1'b0;
  endtask

  // One frame: pulse trigger, then ride out the sweep counting busy cycles and retires.
  task automatic sweep(input logic [3:0] s, output int busy_cycles, output int pulses);
    frame_trigger = 1'b1;
    speed         = s;
    tick();
    frame_trigger = 1'b0;
    busy_cycles   = 0;
    pulses        = 0;
    while (busy && busy_cycles < 40) begin
      if (passed_pulse) pulses++;
      busy_cycles++;
      tick();
    end
    if (passed_pulse) pulses++;
  endtask

  task automatic sweep_n(input logic [3:0] s, input int n);
    int bc, pc;
    for (int k = 0; k < n; k++) sweep(s, bc, pc);
  endtask

  task automatic test_reset();
    tick();
    n_checks++;
    if (occupancy !== 4'd0 || busy !== 1'b0 || spawn_ready !== 1'b0 ||
        passed_pulse !== 1'b0 || frame_overrun !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: occ=%0d busy=%b rdy=%b pass=%b ovr=%b, required 0 0 0 0 0",
               occupancy, busy, spawn_ready, passed_pulse, frame_overrun);
    end
    n_checks++;
    if (obs !== '0) begin
      n_errors++;
      $display("FAIL reset_table: got %h, required all zero", obs);
    end
    rst_in = 1'b0;
    n_checks++;
    if (spawn_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL ready_at_release: got %b, required 0", spawn_ready);
    end
    tick();
    n_checks++;
    if (spawn_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ready_after_release: rdy=%b busy=%b, required 1 0", spawn_ready, busy);
    end
  endtask

  task automatic test_spawn();
    spawn_type  = 2'd2;
    spawn_lane  = 2'd1;
    spawn_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (spawn_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL spawn_ready_%0d: got %b, required 1", i, spawn_ready);
      end
      tick();
      n_checks++;
      if (obs[i] !== {2'd2, 11'd1023, 2'd1, 1'b1} || occupancy !== 4'(i + 1)) begin
        n_errors++;
        $display("FAIL spawn_slot_%0d: entry=%h occ=%0d, required 9ffb occ=%0d",
                 i, obs[i], occupancy, i + 1);
      end
    end
    spawn_valid = 1'b0;
    tick();
    n_checks++;
    if (obs[3] !== 16'h0000 || occupancy !== 4'd3) begin
      n_errors++;
      $display("FAIL spawn_stop: slot3=%h occ=%0d, required 0000 occ=3", obs[3], occupancy);
    end
  endtask

  task automatic test_advance();
    int bc, pc;
    clear_table();
    spawn_one(2'd0, 2'd0);
    sweep_n(4'd15, 61);
    sweep_n(4'd8, 1);
    spawn_one(2'd1, 2'd2);
    sweep_n(4'd15, 6);
    sweep_n(4'd5, 1);
    n_checks++;
    if (obs[0] !== {2'd0, 11'd5, 2'd0, 1'b1} || obs[1] !== {2'd1, 11'd928, 2'd2, 1'b1} ||
        occupancy !== 4'd2) begin
      n_errors++;
      $display("FAIL advance_setup: s0=%h s1=%h occ=%0d, required 0029 s1=pos928 occ=2",
               obs[0], obs[1], occupancy);
    end
    sweep(4'd0, bc, pc);
    n_checks++;
    if (bc != 10 || pc != 0 || obs[0] !== {2'd0, 11'd5, 2'd0, 1'b1} ||
        obs[1] !== {2'd1, 11'd928, 2'd2, 1'b1}) begin
      n_errors++;
      $display("FAIL speed_zero: busy=%0d pulses=%0d s0=%h s1=%h, required 10 0 unchanged",
               bc, pc, obs[0], obs[1]);
    end
    sweep(4'd6, bc, pc);
    n_checks++;
    if (bc != 10) begin
      n_errors++;
      $display("FAIL sweep_len: got %0d busy cycles, required 10", bc);
    end
    n_checks++;
    if (pc != 1) begin
      n_errors++;
      $display("FAIL retire_pulse: got %0d pulses, required 1", pc);
    end
    n_checks++;
    if (obs[0] !== {2'd0, 11'd5, 2'd0, 1'b0} || obs[1] !== {2'd1, 11'd922, 2'd2, 1'b1} ||
        occupancy !== 4'd1) begin
      n_errors++;
      $display("FAIL retire_table: s0=%h s1=%h occ=%0d, required inactive s0, s1 pos922, occ=1",
               obs[0], obs[1], occupancy);
    end
  endtask

  task automatic test_full();
    int bc, pc;
    obstacle_t [9:0] snap;
    clear_table();
    spawn_one(2'd0, 2'd0);
    sweep_n(4'd15, 68);
    spawn_type  = 2'd3;
    spawn_lane  = 2'd2;
    spawn_valid = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    n_checks++;
    if (occupancy !== 4'd10 || spawn_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL full_ready: occ=%0d rdy=%b, required 10 0", occupancy, spawn_ready);
    end
    snap = obs;
    spawn_type = 2'd1;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (obs !== snap || occupancy !== 4'd10 || obs[0] !== {2'd0, 11'd3, 2'd0, 1'b1} ||
        obs[9] !== {2'd3, 11'd1023, 2'd2, 1'b1}) begin
      n_errors++;
      $display("FAIL full_hold: s0=%h s9=%h occ=%0d, required 0019 s9=type3 pos1023 occ=10",
               obs[0], obs[9], occupancy);
    end
    spawn_valid = 1'b0;
    sweep(4'd3, bc, pc);
    n_checks++;
    if (pc != 1 || occupancy !== 4'd9 || obs[0].active !== 1'b0 ||
        obs[5] !== {2'd3, 11'd1020, 2'd2, 1'b1}) begin
      n_errors++;
      $display("FAIL full_retire: pulses=%0d occ=%0d s0=%h s5=%h, required 1 9 inactive pos1020",
               pc, occupancy, obs[0], obs[5]);
    end
    spawn_one(2'd1, 2'd3);
    n_checks++;
    if (obs[0] !== {2'd1, 11'd1023, 2'd3, 1'b1} || occupancy !== 4'd10) begin
      n_errors++;
      $display("FAIL refill_slot0: s0=%h occ=%0d, required 5fff occ=10", obs[0], occupancy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] busy_vec, ovr_vec, exp_busy;
    logic        rdy_gap;
    clear_table();
    busy_vec = '0;
    ovr_vec  = '0;
    rdy_gap  = 1'bx;
    speed    = 4'd1;
    for (int c = 0; c < 30; c++) begin
      busy_vec[c] = busy;
      ovr_vec[c]  = frame_overrun;
      if (c == 11) rdy_gap = spawn_ready;
      frame_trigger = (c == 0 || c == 3 || c == 6);
      tick();
    end
    frame_trigger = 1'b0;
    exp_busy = 32'h003F_F7FE;
    n_checks++;
    if (busy_vec !== exp_busy) begin
      n_errors++;
      $display("FAIL back_to_back_busy: got %h, required %h", busy_vec, exp_busy);
    end
    n_checks++;
    if (ovr_vec !== 32'h0000_0080) begin
      n_errors++;
      $display("FAIL overrun_pulse: got %h, required 00000080", ovr_vec);
    end
    n_checks++;
    if (rdy_gap !== 1'b0) begin
      n_errors++;
      $display("FAIL pending_blocks_spawn: got %b, required 0", rdy_gap);
    end
  endtask

  task automatic test_game_reset_mid_sweep();
    clear_table();
    spawn_one(2'd0, 2'd1);
    spawn_one(2'd0, 2'd1);
    frame_trigger = 1'b1;
    speed         = 4'd15;
    tick();
    frame_trigger = 1'b0;
    tick();
    tick();
    game_reset    = 1'b1;
    spawn_valid   = 1'b1;
    frame_trigger = 1'b1;
    spawn_type    = 2'd3;
    n_checks++;
    if (spawn_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL greset_ready: got %b, required 0", spawn_ready);
    end
    tick();
    game_reset    = 1'b0;
    spawn_valid   = 1'b0;
    frame_trigger = 1'b0;
    n_checks++;
    if (obs !== '0 || occupancy !== 4'd0 || busy !== 1'b0 || passed_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL greset_clear: occ=%0d busy=%b pass=%b table=%h, required 0 0 0 zero",
               occupancy, busy, passed_pulse, obs);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || occupancy !== 4'd0 || passed_pulse !== 1'b0 || obs !== '0) begin
      n_errors++;
      $display("FAIL greset_after: busy=%b occ=%0d pass=%b, required 0 0 0",
               busy, occupancy, passed_pulse);
    end
  endtask

  task automatic test_async_reset();
    spawn_one(2'd2, 2'd2);
    frame_trigger = 1'b1;
    speed         = 4'd4;
    tick();
    frame_trigger = 1'b0;
    tick();
    rst_in = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || occupancy !== 4'd0 || obs !== '0 || spawn_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: busy=%b occ=%0d rdy=%b table=%h, required 0 0 0 zero",
               busy, occupancy, spawn_ready, obs);
    end
    tick();
    rst_in = 1'b0;
    tick();
    n_checks++;
    if (spawn_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL async_recover: rdy=%b busy=%b, required 1 0", spawn_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_advance();
    test_full();
    test_back_to_back();
    test_game_reset_mid_sweep();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
